// File: rtl/spwm_pkg.sv
// Shared types and defaults for the SPWM gate-drive stage.
package spwm_pkg;

  localparam int unsigned DT_W_DEF      = 8;
  localparam int unsigned MIN_PULSE_DEF = 4;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_DT_H,
    ST_HIGH,
    ST_DT_L,
    ST_LOW,
    ST_FAULT
  } dt_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spwm_deadtime.sv
// Complementary gate drive with programmable dead time, enable gate and latched fault.
// Optional minimum HIGH/LOW dwell enabled by defining SPWM_DT_MINPULSE_EN.
module spwm_deadtime
  import spwm_pkg::*;
#(
  parameter int unsigned DT_W      = DT_W_DEF,
  parameter int unsigned MIN_PULSE = MIN_PULSE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            refresh,
  input  logic [DT_W-1:0] dead_time,
  input  logic            enable,
  input  logic            pwm_in,
  input  logic            fault,
  input  logic            fault_clr,
  output logic            out_h,
  output logic            out_l,
  output logic            fault_latched
);

  if (DT_W == 0 || MIN_PULSE == 0) begin : g_bad_params
    $error("DT_W and MIN_PULSE must both be at least 1");
  end

  dt_state_t       state, state_n;
  logic [DT_W-1:0] cnt, cnt_n;
  logic [DT_W-1:0] dt_reg;
  logic            pwm_q;
  logic            fault_s;
  logic            exit_ok;

  sync_2ff u_fault_sync (
    .clk (clk),
    .rst (rst),
    .d   (fault),
    .q   (fault_s)
  );

`ifdef SPWM_DT_MINPULSE_EN
  localparam int unsigned DWELL_W = $clog2(MIN_PULSE + 1);
  logic [DWELL_W-1:0] dwell;

  // dwell counts cycles spent in the current state, saturating at MIN_PULSE
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell <= '0;
    end else if (state_n != state) begin
      dwell <= DWELL_W'(1);
    end else if (dwell < DWELL_W'(MIN_PULSE)) begin
      dwell <= dwell + DWELL_W'(1);
    end
  end

  assign exit_ok = (dwell >= DWELL_W'(MIN_PULSE));
`else
  assign exit_ok = 1'b1;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (fault_s) begin
      state_n = ST_FAULT;
    end else if (state == ST_FAULT) begin
      if (fault_clr) state_n = ST_OFF;
    end else if (!enable) begin
      state_n = ST_OFF;
    end else begin
      case (state)
        ST_OFF: begin
          state_n = ST_DT_L;
          cnt_n   = dt_reg;
        end
        ST_LOW: begin
          if (pwm_q && exit_ok) begin
            state_n = ST_DT_H;
            cnt_n   = dt_reg;
          end
        end
        ST_HIGH: begin
          if (!pwm_q && exit_ok) begin
            state_n = ST_DT_L;
            cnt_n   = dt_reg;
          end
        end
        // out_h was never driven here, so a dropped request can fall straight back to LOW
        ST_DT_H: begin
          if (!pwm_q)                  state_n = ST_LOW;
          else if (cnt == DT_W'(1))    state_n = ST_HIGH;
          else                         cnt_n   = cnt - DT_W'(1);
        end
        ST_DT_L: begin
          if (cnt == DT_W'(1)) state_n = ST_LOW;
          else                 cnt_n   = cnt - DT_W'(1);
        end
        default: state_n = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_OFF;
      cnt           <= '0;
      dt_reg        <= DT_W'(1);
      pwm_q         <= 1'b0;
      out_h         <= 1'b0;
      out_l         <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      pwm_q         <= pwm_in;
      out_h         <= (state_n == ST_HIGH);
      out_l         <= (state_n == ST_LOW);
      fault_latched <= (state_n == ST_FAULT);
      if (refresh) dt_reg <= (dead_time == '0) ? DT_W'(1) : dead_time;
    end
  end

  a_no_overlap: assert property (@(posedge clk) !(out_h && out_l));

endmodule
